// File: rtl/vote_if.sv
// Voter button / ballot bundle between the button front-end driver and vote_capture.
// The master drives the raw buttons and clear; the slave returns the ballot.
interface vote_if;
    logic       A;
    logic       B;
    logic       C;
    logic       clear;
    logic       w;
    logic       n;
    logic       o;
    logic [2:0] voted;
    logic       ballot_valid;
    logic       closed_pulse;

    modport master (
        output A, B, C, clear,
        input  w, n, o, voted, ballot_valid, closed_pulse
    );

    modport slave (
        input  A, B, C, clear,
        output w, n, o, voted, ballot_valid, closed_pulse
    );
endinterface

// File: rtl/vote_capture.sv
// Synchronises and debounces three voter buttons and collects one closed ballot per window.
// Define VOTE_TOGGLE_EN to let repeat presses toggle a voter's choice and restart the window.
module vote_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
    input logic  clk50MHz,
    input logic  rst,
    vote_if.slave bus
);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StClosed} state_e;

    logic [2:0]    raw;
    logic [2:0]    sync1_q;
    logic [2:0]    sync2_q;
    logic [2:0]    deb_q;
    logic [2:0]    deb_prev_q;
    logic [DW-1:0] cnt_q [3];
    logic [2:0]    press;

    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    voted_q;
    logic [2:0]    voted_nxt;
    logic [2:0]    final_nxt;
    logic          w_q;
    logic          n_q;
    logic          o_q;
    logic          ballot_valid_q;
    logic          closed_pulse_q;
`ifdef VOTE_TOGGLE_EN
    logic [2:0]    choice_q;
    logic [2:0]    choice_nxt;
`endif

    assign raw = {bus.C, bus.B, bus.A};

    always_ff @(posedge clk50MHz or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_prev_q <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
        end
    end

    // The debounced level only follows the synced level after it has differed for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk50MHz or negedge rst) begin
        if (!rst) begin
            deb_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (cnt_q[i] == DEB_MAX) begin
                        deb_q[i] <= sync2_q[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + DW'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign press     = deb_q & ~deb_prev_q;
    // voted_q is always zero in IDLE, so the same merge serves the first press too.
    assign voted_nxt = voted_q | press;
`ifdef VOTE_TOGGLE_EN
    assign choice_nxt = (choice_q | (press & ~voted_q)) ^ (press & voted_q);
    assign final_nxt  = choice_nxt;
`else
    assign final_nxt  = voted_nxt;
`endif

    always_ff @(posedge clk50MHz or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            timer_q        <= '0;
            voted_q        <= '0;
            w_q            <= 1'b0;
            n_q            <= 1'b0;
            o_q            <= 1'b0;
            ballot_valid_q <= 1'b0;
            closed_pulse_q <= 1'b0;
`ifdef VOTE_TOGGLE_EN
            choice_q       <= '0;
`endif
        end else begin
            closed_pulse_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    timer_q <= '0;
                    voted_q <= voted_nxt;
`ifdef VOTE_TOGGLE_EN
                    choice_q <= choice_nxt;
`endif
                    if (&press) begin
                        state_q                 <= StClosed;
                        {o_q, n_q, w_q}         <= final_nxt;
                        ballot_valid_q          <= 1'b1;
                        closed_pulse_q          <= 1'b1;
                    end else if (|press) begin
                        state_q <= StCollect;
                    end
                end
                StCollect: begin
                    if (bus.clear) begin
                        state_q <= StIdle;
                        timer_q <= '0;
                        voted_q <= '0;
`ifdef VOTE_TOGGLE_EN
                        choice_q <= '0;
`endif
                    end else begin
                        voted_q <= voted_nxt;
`ifdef VOTE_TOGGLE_EN
                        choice_q <= choice_nxt;
`endif
                        // A press landing on the timeout cycle is already merged above.
                        if (voted_nxt == 3'b111 || timer_q == TMO_MAX) begin
                            state_q         <= StClosed;
                            {o_q, n_q, w_q} <= final_nxt;
                            ballot_valid_q  <= 1'b1;
                            closed_pulse_q  <= 1'b1;
`ifdef VOTE_TOGGLE_EN
                        end else if (|press) begin
                            timer_q <= '0;
`endif
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                end
                StClosed: begin
                    if (bus.clear) begin
                        state_q        <= StIdle;
                        timer_q        <= '0;
                        voted_q        <= '0;
                        w_q            <= 1'b0;
                        n_q            <= 1'b0;
                        o_q            <= 1'b0;
                        ballot_valid_q <= 1'b0;
`ifdef VOTE_TOGGLE_EN
                        choice_q       <= '0;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.w            = w_q;
    assign bus.n            = n_q;
    assign bus.o            = o_q;
    assign bus.voted        = voted_q;
    assign bus.ballot_valid = ballot_valid_q;
    assign bus.closed_pulse = closed_pulse_q;
endmodule

// File: tb/tb_vote_capture.sv
// Directed bench for vote_capture with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20.
// Raw button edge to visible ballot update is 7 clock edges.
module tb_vote_capture;
    logic clk50MHz = 1'b0;
    logic rst      = 1'b0;
    int   errors   = 0;
    int   checks   = 0;

    vote_if bus ();

    vote_capture #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk50MHz(clk50MHz),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk50MHz = ~clk50MHz;

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk50MHz);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // wno is {o, n, w}
    task automatic chk_all(input string tag, input logic [2:0] voted, input logic [2:0] wno,
                           input logic bv, input logic cp);
        chk({tag, ".voted"}, {1'b0, bus.voted}, {1'b0, voted});
        chk({tag, ".onw"}, {1'b0, bus.o, bus.n, bus.w}, {1'b0, wno});
        chk({tag, ".ballot_valid"}, {3'b0, bus.ballot_valid}, {3'b0, bv});
        chk({tag, ".closed_pulse"}, {3'b0, bus.closed_pulse}, {3'b0, cp});
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
    endtask

    task automatic release_all();
        bus.A = 1'b0;
        bus.B = 1'b0;
        bus.C = 1'b0;
        step(10);
    endtask

    initial begin
        bus.A = 1'b0;
        bus.B = 1'b0;
        bus.C = 1'b0;
        bus.clear = 1'b0;
        #12;
        chk_all("reset", 3'b000, 3'b000, 1'b0, 1'b0);
        @(negedge clk50MHz);
        rst = 1'b1;
        step(3);

        // Clean presses 10 cycles apart; C's press also lands on the timeout edge.
        bus.A = 1'b1;
        step(6);
        chk("clean.a_latency", {1'b0, bus.voted}, 4'h0);
        step(1);
        chk_all("clean.a", 3'b001, 3'b000, 1'b0, 1'b0);
        step(3);
        bus.B = 1'b1;
        step(7);
        chk("clean.b", {1'b0, bus.voted}, 4'h3);
        step(3);
        bus.C = 1'b1;
        step(6);
        chk_all("clean.pre_c", 3'b011, 3'b000, 1'b0, 1'b0);
        step(1);
        chk_all("clean.c", 3'b111, 3'b111, 1'b1, 1'b1);
        step(1);
        chk_all("clean.after", 3'b111, 3'b111, 1'b1, 1'b0);
        pulse_clear();
        chk_all("closed.clear", 3'b000, 3'b000, 1'b0, 1'b0);
        release_all();

        // Bounce: 2-cycle pulses never survive the 4-cycle debounce.
        for (int i = 0; i < 3; i++) begin
            bus.A = 1'b1;
            step(2);
            bus.A = 1'b0;
            step(2);
        end
        bus.A = 1'b1;
        step(6);
        chk("bounce.none", {1'b0, bus.voted}, 4'h0);
        step(1);
        chk_all("bounce.one", 3'b001, 3'b000, 1'b0, 1'b0);
        step(5);
        chk("bounce.hold", {1'b0, bus.voted}, 4'h1);
        pulse_clear();
        chk("bounce.clear", {1'b0, bus.voted}, 4'h0);
        release_all();

        // Timeout with only B voting.
        bus.B = 1'b1;
        step(7);
        chk_all("tmo.enter", 3'b010, 3'b000, 1'b0, 1'b0);
        step(19);
        chk("tmo.early", {3'b0, bus.ballot_valid}, 4'h0);
        step(1);
        chk_all("tmo.close", 3'b010, 3'b010, 1'b1, 1'b1);
        step(1);
        chk("tmo.pulse_once", {3'b0, bus.closed_pulse}, 4'h0);

        // Asynchronous reset while CLOSED.
        bus.B = 1'b0;
        rst = 1'b0;
        #1;
        chk_all("rst.closed", 3'b000, 3'b000, 1'b0, 1'b0);
        step(2);
        rst = 1'b1;
        step(10);

        // clear in COLLECT with voted=011; held buttons must not re-vote.
        bus.A = 1'b1;
        bus.B = 1'b1;
        step(7);
        chk_all("clr.collect", 3'b011, 3'b000, 1'b0, 1'b0);
        step(2);
        pulse_clear();
        chk_all("clr.idle", 3'b000, 3'b000, 1'b0, 1'b0);
        step(10);
        chk("clr.held", {1'b0, bus.voted}, 4'h0);
        release_all();

        // All three together from IDLE close immediately.
        bus.A = 1'b1;
        bus.B = 1'b1;
        bus.C = 1'b1;
        step(6);
        chk("sim3.pre", {1'b0, bus.voted}, 4'h0);
        step(1);
        chk_all("sim3.close", 3'b111, 3'b111, 1'b1, 1'b1);
        pulse_clear();
        release_all();

        // Second press on the timeout edge is still recorded.
        bus.A = 1'b1;
        step(7);
        chk("tmopress.a", {1'b0, bus.voted}, 4'h1);
        step(13);
        bus.B = 1'b1;
        step(6);
        chk_all("tmopress.pre", 3'b001, 3'b000, 1'b0, 1'b0);
        step(1);
        chk_all("tmopress.close", 3'b011, 3'b011, 1'b1, 1'b1);
        pulse_clear();
        release_all();

        // clear on the same edge as C's press wins.
        bus.A = 1'b1;
        step(7);
        chk("clrpress.a", {1'b0, bus.voted}, 4'h1);
        step(1);
        bus.C = 1'b1;
        step(6);
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        chk_all("clrpress.idle", 3'b000, 3'b000, 1'b0, 1'b0);
        step(3);
        chk("clrpress.stay", {1'b0, bus.voted}, 4'h0);
        release_all();

        // A pressed twice, then B.
        bus.A = 1'b1;
        step(7);
        chk("rep.a1", {1'b0, bus.voted}, 4'h1);
        step(1);
        bus.A = 1'b0;
        step(8);
        bus.A = 1'b1;
        step(8);
        bus.A = 1'b0;
`ifdef VOTE_TOGGLE_EN
        step(6);
        bus.B = 1'b1;
        step(7);
        chk_all("tog.b", 3'b011, 3'b000, 1'b0, 1'b0);
        step(1);
        bus.B = 1'b0;
        step(18);
        chk("tog.early", {3'b0, bus.ballot_valid}, 4'h0);
        step(1);
        chk_all("tog.close", 3'b011, 3'b010, 1'b1, 1'b1);
`else
        step(2);
        chk("rep.early", {3'b0, bus.ballot_valid}, 4'h0);
        step(1);
        chk_all("rep.close", 3'b001, 3'b001, 1'b1, 1'b1);
        step(3);
        bus.B = 1'b1;
        step(8);
        chk_all("rep.closed_ignore", 3'b001, 3'b001, 1'b1, 1'b0);
        bus.B = 1'b0;
`endif
        pulse_clear();
        release_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
